// File: rtl/sdram_port_arbiter.sv
// Arbitrates the capture write FIFO and the display read FIFO onto a single SDRAM
// controller call/done handshake, and manages burst addresses and double-buffered frame banks.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int BURST       = 8,
  parameter int FRAME_WORDS = 130560,
  parameter int TIMEOUT     = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              rd_urgent,
  input  logic              vsync,
  input  logic [1:0]        sd_done,
  output logic [1:0]        sd_call,
  output logic [ADDR_W:0]   sd_addr,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              wr_frame_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - BURST);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;
  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_bank;
  logic              rd_bank;
  logic              vsync_pend;
  logic [CNT_W-1:0]  wait_cnt;

  logic              pick_wr;
  logic              pick_rd;
  logic [ADDR_W-1:0] rd_addr_now;
  logic              rd_bank_now;

  // Grant decision and the read start address seen by a grant in the same cycle as vsync.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_wr     = 1'b0;
    pick_rd     = 1'b0;
    rd_addr_now = rd_addr;
    rd_bank_now = rd_bank;
    if (en) begin
      if (rd_urgent && rd_req) begin
        pick_rd = 1'b1;
      end else if (wr_req && rd_req) begin
        pick_wr = (last_grant == GRANT_READ);
        pick_rd = (last_grant == GRANT_WRITE);
      end else begin
        pick_wr = wr_req;
        pick_rd = rd_req;
      end
    end
    if (vsync) begin
      rd_addr_now = '0;
      rd_bank_now = ~wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= GRANT_READ;
      sd_call       <= 2'b00;
      sd_addr       <= '0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b1;
      vsync_pend    <= 1'b0;
      wait_cnt      <= '0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      wr_frame_done <= 1'b0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      wr_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync) begin
            rd_addr <= '0;
            rd_bank <= ~wr_bank;
          end
          if (pick_wr) begin
            state      <= WR_BUSY;
            sd_call    <= 2'b10;
            sd_addr    <= {wr_bank, wr_addr};
            last_grant <= GRANT_WRITE;
            busy       <= 1'b1;
            wait_cnt   <= '0;
          end else if (pick_rd) begin
            state      <= RD_BUSY;
            sd_call    <= 2'b01;
            sd_addr    <= {rd_bank_now, rd_addr_now};
            last_grant <= GRANT_READ;
            busy       <= 1'b1;
            wait_cnt   <= '0;
          end
        end
        WR_BUSY: begin
          // The read restart samples wr_bank before any toggle at this edge.
          if (vsync) begin
            rd_addr <= '0;
            rd_bank <= ~wr_bank;
          end
          if (sd_done[1]) begin
            state   <= IDLE;
            sd_call <= 2'b00;
            busy    <= 1'b0;
            wr_ack  <= 1'b1;
            if (wr_addr == LAST_ADDR) begin
              wr_addr       <= '0;
              wr_bank       <= ~wr_bank;
              wr_frame_done <= 1'b1;
            end else begin
              wr_addr <= wr_addr + STEP;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state       <= IDLE;
            sd_call     <= 2'b00;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD_BUSY: begin
          if (sd_done[0]) begin
            state      <= IDLE;
            sd_call    <= 2'b00;
            busy       <= 1'b0;
            rd_ack     <= 1'b1;
            vsync_pend <= 1'b0;
            if (vsync_pend || vsync || rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              rd_bank <= ~wr_bank;
            end else begin
              rd_addr <= rd_addr + STEP;
            end
          end else begin
            if (vsync) vsync_pend <= 1'b1;
            if (wait_cnt == CNT_LAST) begin
              state       <= IDLE;
              sd_call     <= 2'b00;
              busy        <= 1'b0;
              err_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          sd_call <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a transaction-level model checked every cycle,
// a responsive controller stand-in, and hand-computed checkpoints.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ADDR_W      = 18;
  localparam int BURST       = 8;
  localparam int FRAME_WORDS = 130560;
  localparam int TIMEOUT     = 4095;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              wr_req = 1'b0;
  logic              rd_req = 1'b0;
  logic              rd_urgent = 1'b0;
  logic              vsync = 1'b0;
  logic [1:0]        sd_done = 2'b00;
  logic [1:0]        sd_call;
  logic [ADDR_W:0]   sd_addr;
  logic              wr_ack;
  logic              rd_ack;
  logic              wr_frame_done;
  logic              busy;
  logic              err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .BURST(BURST), .FRAME_WORDS(FRAME_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_req(wr_req), .rd_req(rd_req),
    .rd_urgent(rd_urgent), .vsync(vsync), .sd_done(sd_done), .sd_call(sd_call),
    .sd_addr(sd_addr), .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_frame_done(wr_frame_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller stand-in: answers the active call after resp_delay cycles.
  bit       resp_en = 1'b0;
  int       resp_delay = 1;
  int       resp_cnt = 0;
  bit       inject_rd_done = 1'b0;
  bit [1:0] resp_d;
  always @(negedge clk) begin
    resp_d = 2'b00;
    if (resp_en && sd_call != 2'b00) begin
      resp_cnt++;
      if (resp_cnt >= resp_delay) begin
        resp_d   = sd_call;
        resp_cnt = 0;
      end
    end else begin
      resp_cnt = 0;
    end
    sd_done = resp_d | {1'b0, inject_rd_done};
  end

  // Transaction-level model: current op, per-port word pointers and banks.
  typedef enum {M_IDLE, M_WR, M_RD} m_state_t;
  m_state_t m_state = M_IDLE;
  bit       m_last_wr = 1'b0;
  int       m_wa = 0, m_ra = 0, m_wait = 0, m_addr = 0;
  bit       m_wb = 1'b0, m_rb = 1'b1, m_pend = 1'b0, m_err = 1'b0;
  bit [1:0] m_call = 2'b00;
  bit       m_wack = 1'b0, m_rack = 1'b0, m_fd = 1'b0;

  task automatic model_reset();
    m_state = M_IDLE; m_last_wr = 1'b0; m_wa = 0; m_ra = 0; m_wait = 0; m_addr = 0;
    m_wb = 1'b0; m_rb = 1'b1; m_pend = 1'b0; m_err = 1'b0; m_call = 2'b00;
    m_wack = 1'b0; m_rack = 1'b0; m_fd = 1'b0;
  endtask

  task automatic rd_restart();
    m_ra = 0;
    m_rb = !m_wb;
  endtask

  task automatic model_step();
    bit go_rd, go_wr;
    m_wack = 1'b0; m_rack = 1'b0; m_fd = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (vsync) rd_restart();
        go_rd = en && rd_req && (rd_urgent || !wr_req || m_last_wr);
        go_wr = en && wr_req && !go_rd;
        if (go_wr) begin
          m_state = M_WR; m_call = 2'b10; m_last_wr = 1'b1; m_wait = 0;
          m_addr = (int'(m_wb) << ADDR_W) + m_wa;
        end else if (go_rd) begin
          m_state = M_RD; m_call = 2'b01; m_last_wr = 1'b0; m_wait = 0;
          m_addr = (int'(m_rb) << ADDR_W) + m_ra;
        end
      end
      M_WR: begin
        if (vsync) rd_restart();
        if (sd_done[1]) begin
          m_state = M_IDLE; m_call = 2'b00; m_wack = 1'b1;
          m_wa = m_wa + BURST;
          if (m_wa == FRAME_WORDS) begin
            m_wa = 0; m_wb = !m_wb; m_fd = 1'b1;
          end
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_state = M_IDLE; m_call = 2'b00; m_err = 1'b1;
          end
        end
      end
      default: begin
        if (vsync) m_pend = 1'b1;
        if (sd_done[0]) begin
          m_state = M_IDLE; m_call = 2'b00; m_rack = 1'b1;
          m_ra = m_ra + BURST;
          if (m_pend || m_ra == FRAME_WORDS) rd_restart();
          m_pend = 1'b0;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_state = M_IDLE; m_call = 2'b00; m_err = 1'b1;
          end
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("cycle sd_call/sd_addr", {sd_call, sd_addr}, {m_call, m_addr[ADDR_W:0]});
    check("cycle ack/frame/busy/err", {wr_ack, rd_ack, wr_frame_done, busy, err_timeout},
          {m_wack, m_rack, m_fd, m_state != M_IDLE, m_err});
  end

  task automatic wait_grant(output logic [1:0] c, output logic [ADDR_W:0] a, output int n);
    n = 0;
    @(negedge clk);
    while (sd_call == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("grant arrives within budget", sd_call != 2'b00, 1'b1);
    c = sd_call;
    a = sd_addr;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (sd_call != 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("op returns to idle", sd_call, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0;
    vsync = 1'b0; resp_en = 1'b0; inject_rd_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0]      c;
  logic [ADDR_W:0] a;
  logic [ADDR_W:0] saved_addr;
  int              n, lat, iter;
  logic [1:0]      rr_call [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [ADDR_W:0] rr_addr [4] = '{19'h00000, 19'h40000, 19'h00008, 19'h40008};

  initial begin
    // Reset state.
    do_reset();
    check("reset sd_call", sd_call, 2'b00);
    check("reset sd_addr", sd_addr, 19'h0);
    check("reset busy/err/pulses", {busy, err_timeout, wr_ack, rd_ack, wr_frame_done}, 5'b0);

    // Single write requester, controller answers after 20 cycles.
    resp_en = 1'b1; resp_delay = 20;
    en = 1'b1; wr_req = 1'b1;
    wait_grant(c, a, n);
    check("t1 write call", c, 2'b10);
    check("t1 grant latency", n, 0);
    check("t1 first addr", a, 19'h0);
    wait_idle(100, lat);
    check("t1 call held until done", lat, 20);
    check("t1 wr_ack pulse", wr_ack, 1'b1);
    wait_grant(c, a, n);
    check("t1 second addr", a, 19'h8);
    check("t1 idle gap then grant", n, 0);
    wr_req = 1'b0;
    wait_idle(100, lat);

    // Round-robin with both requests held.
    do_reset();
    resp_en = 1'b1; resp_delay = 2;
    en = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(c, a, n);
      check("t2 rr call", c, rr_call[i]);
      check("t2 rr addr", a, rr_addr[i]);
      wait_idle(100, lat);
    end

    // Urgent read locks out writes.
    do_reset();
    resp_en = 1'b1; resp_delay = 2;
    en = 1'b1; wr_req = 1'b1; rd_req = 1'b1; rd_urgent = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(c, a, n);
      check("t3 urgent call", c, 2'b01);
      check("t3 urgent addr", a, 19'h40000 + 19'(8 * i));
      wait_idle(100, lat);
    end

    // Full frame of interleaved writes and reads: write wrap, then read wrap.
    do_reset();
    resp_en = 1'b1; resp_delay = 1;
    en = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    while (!wr_frame_done && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("t4 wr_frame_done seen", wr_frame_done, 1'b1);
    check("t4 frame done with wr_ack", wr_ack, 1'b1);
    wait_grant(c, a, n);
    check("t4 last read of frame", {c, a}, {2'b01, 19'h5FDF8});
    wait_idle(100, lat);
    wait_grant(c, a, n);
    check("t4 write after wrap uses bank 1", {c, a}, {2'b10, 19'h40000});
    wait_idle(100, lat);
    wait_grant(c, a, n);
    check("t4 read after wrap uses bank 0", {c, a}, {2'b01, 19'h00000});
    wr_req = 1'b0;

    // vsync during a read at word 800, then vsync while idle.
    resp_delay = 4;
    iter = 0;
    while (a != 19'd800 && iter < 150) begin
      wait_idle(100, lat);
      wait_grant(c, a, n);
      iter++;
    end
    check("t5 reached rd_addr 800", a, 19'd800);
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    wait_idle(100, lat);
    check("t5 rd_ack after vsync read", rd_ack, 1'b1);
    wait_grant(c, a, n);
    check("t5 restart after pending vsync", {c, a}, {2'b01, 19'h00000});
    wait_idle(100, lat);
    wait_grant(c, a, n);
    check("t5 normal step after restart", a, 19'h00008);
    rd_req = 1'b0;
    wait_idle(100, lat);
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk); vsync = 1'b0; rd_req = 1'b1;
    wait_grant(c, a, n);
    check("t5 restart after idle vsync", {c, a}, {2'b01, 19'h00000});
    wait_idle(100, lat);
    rd_req = 1'b0;

    // Timeout in WR_BUSY with a stray read done.
    resp_en = 1'b0; wr_req = 1'b1;
    wait_grant(c, a, n);
    saved_addr = a;
    check("t6 write addr before timeout", {c, a}, {2'b10, 19'h40008});
    @(negedge clk); inject_rd_done = 1'b1;
    @(negedge clk); inject_rd_done = 1'b0;
    wait_idle(TIMEOUT + 20, lat);
    check("t6 cycles to timeout", lat + 2, TIMEOUT);
    check("t6 err_timeout set", err_timeout, 1'b1);
    check("t6 no wr_ack on timeout", wr_ack, 1'b0);
    wait_grant(c, a, n);
    check("t6 retry same addr", a, saved_addr);
    resp_en = 1'b1; resp_delay = 3;
    wait_idle(100, lat);
    check("t6 retry acked", wr_ack, 1'b1);
    check("t6 err_timeout sticky", err_timeout, 1'b1);

    // en low blocks grants; en low in BUSY lets the op finish.
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("t7 no grant with en low", sd_call, 2'b00);
    en = 1'b1;
    wait_grant(c, a, n);
    check("t7 grant after en", {c, n[3:0]}, {2'b10, 4'd0});
    en = 1'b0;
    wait_idle(100, lat);
    check("t7 op completes with en low", wr_ack, 1'b1);
    repeat (5) @(negedge clk);
    check("t7 no regrant with en low", sd_call, 2'b00);

    // Reset in the middle of an op.
    en = 1'b1; resp_en = 1'b0;
    wait_grant(c, a, n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t8 async reset drops call", {sd_call, busy}, 3'b000);
    check("t8 async reset clears err/addr", {err_timeout, sd_addr}, 20'h0);
    en = 1'b0; wr_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Schedules accesses to the SDRAM control FSM for two requesters: the photon-capture write FIFO and the TFT display read FIFO.
- Turns their request levels into one-hot write/read calls toward the controller and holds each call until the controller's done pulse.
- Generates burst addresses and manages double-buffered frame banks, so capture writes one bank while the display reads the other.
- Refresh and initialisation stay inside the controller; this block only waits longer for done while they run.

Parameters:
- ADDR_W, 18: in-bank word address width.
- BURST, 8: words per controller access; address step per completed op.
- FRAME_WORDS, 130560: words per frame (480x272). Must be a multiple of BURST and fit in ADDR_W bits.
- TIMEOUT, 4095: maximum cycles a call may wait for done before it is abandoned.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- en, in, 1: grant enable. Low blocks new grants; an in-flight op still completes.
- wr_req, in, 1: level; capture FIFO holds at least BURST words.
- rd_req, in, 1: level; display FIFO has room for BURST words.
- rd_urgent, in, 1: level; display FIFO is near empty, so read gets absolute priority.
- vsync, in, 1: one-cycle pulse; restart display read at frame start.
- sd_done, in, 2: from controller. [1] = write done, [0] = read done. One-cycle pulses.
- sd_call, out, 2: to controller. [1] = write call, [0] = read call. At most one bit is set.
- sd_addr, out, ADDR_W+1: {bank, word address} for the current op.
- wr_ack, out, 1: one-cycle pulse; a write burst is done and the FIFO may pop.
- rd_ack, out, 1: one-cycle pulse; a read burst is done and the FIFO may push.
- wr_frame_done, out, 1: one-cycle pulse; the final burst of a frame has been written.
- busy, out, 1: high in WR_BUSY or RD_BUSY.
- err_timeout, out, 1: sticky error flag; cleared only by reset.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, sd_call=00, sd_addr=0, wr_addr=0, rd_addr=0, wr_bank=0, rd_bank=1, last_grant=READ, every pulse output=0, err_timeout=0, vsync_pend=0.
- States and transitions:
  - IDLE, en=1: grant read if rd_urgent&rd_req. Otherwise, if only one request is active, grant it. If both are active, grant the one opposite last_grant (round-robin).
  - WR_BUSY: sd_call=10, sd_addr={wr_bank,wr_addr}.
  - RD_BUSY: sd_call=01, sd_addr={rd_bank,rd_addr}.
  - IDLE, en=0 or no request: hold; sd_call=00.
- Grant latency: request sampled in IDLE at edge N; sd_call and sd_addr are valid after edge N. last_grant updates at grant.
- Completion, write: sd_done[1] in WR_BUSY clears sd_call at the same edge. At that edge, pulse wr_ack and return to IDLE.
- Completion, read: sd_done[0] in RD_BUSY clears sd_call at the same edge. At that edge, pulse rd_ack and return to IDLE.
- Minimum spacing: at least one IDLE cycle between consecutive calls. This matches the controller's done-handshake turnaround.
- Write address update on completion: wr_addr += BURST. If wr_addr == FRAME_WORDS-BURST: wr_addr=0, wr_bank toggles, wr_frame_done pulses.
- Read address update on completion: rd_addr += BURST. If rd_addr == FRAME_WORDS-BURST: rd_addr=0, and rd_bank = ~wr_bank as sampled at that edge (last fully written bank).
- vsync outside RD_BUSY: rd_addr=0 and rd_bank=~wr_bank on the next edge.
- vsync during RD_BUSY: set vsync_pend. On completion, apply the vsync restart instead of the normal increment, then clear vsync_pend.
- Mismatched or out-of-state done: a done bit not matching the current call, or any done in IDLE, is ignored. No state or address change.
- Timeout: a cycle counter runs in the BUSY states and clears on entry. At TIMEOUT cycles without a matching done: drop sd_call, set err_timeout, return to IDLE. Address is not advanced and no ack pulses.
- Request drop: wr_req/rd_req falling during BUSY has no effect; the op completes.
- en going low in BUSY: the op completes normally; no new grant afterwards.
- Reset mid-operation: sd_call drops immediately; all state returns to reset values.

Test Plan:
- Reset, then wr_req=1 only: sd_call=10 one cycle after request, sd_addr=0. Done after 20 cycles gives wr_ack pulse, sd_call=00, and the next grant has sd_addr=8.
- wr_req=rd_req=1 held, rd_urgent=0: grants alternate W,R,W,R starting with write (last_grant reset=READ).
- Same as previous with rd_urgent=1: four consecutive read grants, no write granted, rd_addr goes 0,8,16,24.
- Write 16320 bursts: the last done pulses wr_frame_done, wr_addr=0, and write sd_addr bank bit=1. A read wrap afterwards sets rd_bank=0.
- vsync during RD_BUSY at rd_addr=800: ack pulses, then the next read grant has sd_addr={~wr_bank,0}. vsync in IDLE gives the same result one edge later.
- No done for TIMEOUT cycles in WR_BUSY: sd_call=00, err_timeout=1 (sticky), no wr_ack, and the retried write uses the same sd_addr. A sd_done[0] injected during WR_BUSY is ignored.
